// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result bundle between an operand source, a
// serial_adder and a result consumer.
//   start, a_in, b_in, carry_in : load request and operands (source -> adder)
//   busy, done                  : status (adder -> source/consumer)
//   sum_out, carry_out          : result (adder -> consumer)
interface serial_adder_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             carry_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum_out;
   logic             carry_out;

   // Operand source / result consumer side
   modport master (
      output start, a_in, b_in, carry_in,
      input  busy, done, sum_out, carry_out
   );

   // Adder side
   modport slave (
      input  start, a_in, b_in, carry_in,
      output busy, done, sum_out, carry_out
   );
endinterface

// File: rtl/serial_adder.sv
// full_adder: single-bit combinational full adder.
//   a, b, cin : addend bits and carry in
//   sum_c     : a ^ b ^ cin
//   carry_c   : majority(a, b, cin)
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum_c,
   output logic carry_c
);
   assign sum_c   = a ^ b ^ cin;
   assign carry_c = (a & b) | (a & cin) | (b & cin);
endmodule

// serial_adder: bit-serial adder, one bit per clock, LSB first. Operands are
// captured on an accepted start, the carry loop closes through c_q, and the
// result is published to sum_out/carry_out only on the completion edge.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : serial_adder_if slave (start/a_in/b_in/carry_in in,
//          busy/done/sum_out/carry_out out, all outputs registered)
module serial_adder #(
   parameter int unsigned WIDTH = 8
) (
   input logic           clk,
   input logic           rst,
   serial_adder_if.slave bus
);
   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] s_sr_q, s_sr_d;
   logic             c_q, c_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;

   logic             fa_sum_c;
   logic             fa_carry_c;
   logic             last_bit_c;

   // The one arithmetic cell; always looks at the LSBs of the shifters
   full_adder u_fa (
      .a       (a_sr_q[0]),
      .b       (b_sr_q[0]),
      .cin     (c_q),
      .sum_c   (fa_sum_c),
      .carry_c (fa_carry_c)
   );

   assign last_bit_c = (cnt_q == CW'(WIDTH - 1));

   // State and datapath register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         s_sr_q  <= '0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         s_sr_q  <= s_sr_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
      end
   end

   // Next state, datapath and next-output logic
   always_comb begin
      state_d = state_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      s_sr_d  = s_sr_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      sum_d   = sum_q;
      carry_d = carry_q;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = ADD;
               a_sr_d  = bus.a_in;
               b_sr_d  = bus.b_in;
               c_d     = bus.carry_in;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end
         end
         ADD: begin
            a_sr_d = a_sr_q >> 1;
            b_sr_d = b_sr_q >> 1;
            s_sr_d = {fa_sum_c, s_sr_q[WIDTH-1:1]};
            c_d    = fa_carry_c;
            cnt_d  = cnt_q + CW'(1);
            busy_d = !last_bit_c;
            if (last_bit_c) begin
               // Publish the full result on the same edge the final bit lands
               state_d = DONE;
               done_d  = 1'b1;
               sum_d   = {fa_sum_c, s_sr_q[WIDTH-1:1]};
               carry_d = fa_carry_c;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.sum_out   = sum_q;
   assign bus.carry_out = carry_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and exhaustive checks of serial_adder at WIDTH=8
// and WIDTH=4, with a per-cycle timing/result model for both instances.
module tb_serial_adder;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   serial_adder_if #(.WIDTH(8)) bus8 ();
   serial_adder_if #(.WIDTH(4)) bus4 ();

   serial_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
   serial_adder #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Model: phase 0 idle, 1..W adding, W+1 result cycle
   int         m8_phase, m4_phase;
   logic [8:0] m8_pend, m8_res;
   logic [4:0] m4_pend, m4_res;

   always @(posedge clk) begin
      if (rst) begin
         m8_phase <= 0;
         m8_res   <= '0;
      end else if (m8_phase == 0) begin
         if (bus8.start) begin
            m8_phase <= 1;
            m8_pend  <= 9'(bus8.a_in) + 9'(bus8.b_in) + 9'(bus8.carry_in);
         end
      end else if (m8_phase < 8) begin
         m8_phase <= m8_phase + 1;
      end else if (m8_phase == 8) begin
         m8_phase <= 9;
         m8_res   <= m8_pend;
      end else begin
         m8_phase <= 0;
      end
   end

   always @(posedge clk) begin
      if (rst) begin
         m4_phase <= 0;
         m4_res   <= '0;
      end else if (m4_phase == 0) begin
         if (bus4.start) begin
            m4_phase <= 1;
            m4_pend  <= 5'(bus4.a_in) + 5'(bus4.b_in) + 5'(bus4.carry_in);
         end
      end else if (m4_phase < 4) begin
         m4_phase <= m4_phase + 1;
      end else if (m4_phase == 4) begin
         m4_phase <= 5;
         m4_res   <= m4_pend;
      end else begin
         m4_phase <= 0;
      end
   end

   // Compare both instances against the model every cycle
   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy8",  64'(bus8.busy), 64'(m8_phase >= 1 && m8_phase <= 8));
         chk("done8",  64'(bus8.done), 64'(m8_phase == 9));
         chk("res8",   64'({bus8.carry_out, bus8.sum_out}), 64'(m8_res));
         chk("busy4",  64'(bus4.busy), 64'(m4_phase >= 1 && m4_phase <= 4));
         chk("done4",  64'(bus4.done), 64'(m4_phase == 5));
         chk("res4",   64'({bus4.carry_out, bus4.sum_out}), 64'(m4_res));
      end
   end

   task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic c);
      @(negedge clk);
      bus8.start = 1'b1; bus8.a_in = a; bus8.b_in = b; bus8.carry_in = c;
      @(negedge clk);
      bus8.start = 1'b0;
      bus8.a_in = 8'($urandom); bus8.b_in = 8'($urandom); bus8.carry_in = 1'($urandom);
   endtask

   task automatic start4(input logic [3:0] a, input logic [3:0] b, input logic c);
      @(negedge clk);
      bus4.start = 1'b1; bus4.a_in = a; bus4.b_in = b; bus4.carry_in = c;
      @(negedge clk);
      bus4.start = 1'b0;
      bus4.a_in = 4'($urandom); bus4.b_in = 4'($urandom); bus4.carry_in = 1'($urandom);
   endtask

   // Leaves the bench on the negedge of the done cycle
   task automatic wait_done(input bit w4, input string nm);
      bit seen = 1'b0;
      for (int k = 0; k < 30 && !seen; k++) begin
         if (w4 ? bus4.done : bus8.done) seen = 1'b1;
         else @(negedge clk);
      end
      chk(nm, 64'(seen), 64'd1);
   endtask

   initial begin
      int busy_n, done_n, done_at;

      rst = 1'b1;
      bus8.start = 1'b0; bus8.a_in = '0; bus8.b_in = '0; bus8.carry_in = 1'b0;
      bus4.start = 1'b0; bus4.a_in = '0; bus4.b_in = '0; bus4.carry_in = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy8", 64'(bus8.busy), 64'd0);
      chk("rst_done8", 64'(bus8.done), 64'd0);
      chk("rst_res8",  64'({bus8.carry_out, bus8.sum_out}), 64'd0);
      chk("rst_res4",  64'({bus4.carry_out, bus4.sum_out}), 64'd0);
      rst = 1'b0;
      chk_en = 1'b1;

      // 5A + 3C + 1: busy count, done position and result
      start8(8'h5A, 8'h3C, 1'b1);
      busy_n = 0; done_n = 0; done_at = 0;
      for (int k = 0; k < 14; k++) begin
         if (bus8.busy) busy_n++;
         if (bus8.done) begin
            done_n++;
            done_at = k + 1;
            chk("t1_sum",   64'(bus8.sum_out), 64'h97);
            chk("t1_cout",  64'(bus8.carry_out), 64'd0);
            chk("t1_model", 64'(m8_res), 64'h097);
         end
         @(negedge clk);
      end
      chk("t1_busy_cycles", 64'(busy_n), 64'd8);
      chk("t1_done_count",  64'(done_n), 64'd1);
      chk("t1_done_cycle",  64'(done_at), 64'd9);

      // FF + 01: carry ripples through every bit
      start8(8'hFF, 8'h01, 1'b0);
      wait_done(1'b0, "t2_timeout");
      chk("t2_sum",  64'(bus8.sum_out), 64'h00);
      chk("t2_cout", 64'(bus8.carry_out), 64'd1);

      // Second start while busy is dropped
      start8(8'h10, 8'h20, 1'b0);
      @(negedge clk);
      @(negedge clk);
      bus8.start = 1'b1; bus8.a_in = 8'hFF; bus8.b_in = 8'hFF;
      @(negedge clk);
      bus8.start = 1'b0;
      done_n = 0;
      for (int k = 0; k < 20; k++) begin
         if (bus8.done) begin
            done_n++;
            chk("t3_sum",  64'(bus8.sum_out), 64'h30);
            chk("t3_cout", 64'(bus8.carry_out), 64'd0);
         end
         @(negedge clk);
      end
      chk("t3_done_count", 64'(done_n), 64'd1);

      // Reset at busy cycle 4
      start8(8'hAA, 8'h55, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t4_busy", 64'(bus8.busy), 64'd0);
      chk("t4_done", 64'(bus8.done), 64'd0);
      chk("t4_sum",  64'(bus8.sum_out), 64'd0);
      chk("t4_cout", 64'(bus8.carry_out), 64'd0);
      done_n = 0;
      for (int k = 0; k < 15; k++) begin
         if (bus8.done) done_n++;
         @(negedge clk);
      end
      chk("t4_no_done", 64'(done_n), 64'd0);
      start8(8'h01, 8'h01, 1'b0);
      wait_done(1'b0, "t4_timeout");
      chk("t4_fresh_sum", 64'(bus8.sum_out), 64'h02);

      // Outputs hold while operands wiggle with start low
      @(negedge clk);
      for (int k = 0; k < 20; k++) begin
         bus8.a_in = 8'($urandom); bus8.b_in = 8'($urandom);
         @(negedge clk);
         chk("t5_sum",  64'(bus8.sum_out), 64'h02);
         chk("t5_cout", 64'(bus8.carry_out), 64'd0);
         chk("t5_done", 64'(bus8.done), 64'd0);
      end

      // rst and start together: request not accepted
      rst = 1'b1; bus8.start = 1'b1; bus8.a_in = 8'h01; bus8.b_in = 8'h01;
      @(negedge clk);
      rst = 1'b0; bus8.start = 1'b0;
      chk("t6_busy_a", 64'(bus8.busy), 64'd0);
      @(negedge clk);
      chk("t6_busy_b", 64'(bus8.busy), 64'd0);

      // WIDTH=4 exhaustive, back-to-back
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            for (int c = 0; c < 2; c++) begin
               start4(4'(a), 4'(b), 1'(c));
               wait_done(1'b1, "ex_timeout");
               chk("ex_res", 64'({bus4.carry_out, bus4.sum_out}), 64'(a + b + c));
            end

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
